hazard_controller: RTL and testbench
====================================

Name: hazard_controller

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives the execute-stage operand forwarding selects (forwardAE/forwardBE).
- Generates fetch, decode and execute stall/flush controls for load-use hazards and taken branches/jumps.
- Sequences multi-cycle execute operations (iterative mul/div) by holding the front of the pipe until the unit reports completion, with a timeout watchdog.

Parameters:
- MC_TIMEOUT, 64: maximum BUSY cycles before the watchdog aborts the multi-cycle op.
- CNT_W, 7: width of the BUSY cycle counter; must satisfy 2^CNT_W > MC_TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous, active-low reset (0 = reset, 1 = run).
- rs1D, rs2D  input  5  source registers of the instruction in decode.
- rs1E, rs2E  input  5  source registers of the instruction in execute.
- rdE, rdM, rdW  input  5  destination registers in execute, memory and writeback.
- regwriteM, regwriteW  input  1  register-write enables in memory and writeback.
- resultsrcE  input  2  result select in execute; 2'b01 = load.
- pcsrcE  input  1  taken branch or jump redirect from execute.
- mcstartE  input  1  execute holds a multi-cycle op (level, held while the op sits in execute).
- mcdoneE  input  1  multi-cycle unit result valid this cycle.
- forwardAE, forwardBE  output  2  operand A/B select: 00 register file, 01 resultW, 10 aluresultM.
- stallF, stallD, stallE  output  1  hold PC, IF/ID and ID/EX registers.
- flushD, flushE  output  1  bubble the IF/ID and ID/EX registers.
- mc_busy  output  1  sequencer is in BUSY.
- mc_err  output  1  sticky timeout flag.

Behaviour:
- Reset (rst=0 at clk edge): state=IDLE, counter=0, mc_err=0.
  - While rst=0, all combinational outputs are forced to 0.
- Forwarding (combinational, per operand X in {1,2}):
  - Select 10 if regwriteM, rdM!=0 and rdM==rsXE.
  - Else select 01 if regwriteW, rdW!=0 and rdW==rsXE.
  - Else 00.
  - Memory stage wins over writeback when both match.
- Load-use hazard: lwstall = (resultsrcE==2'b01) & (rdE!=0) & (rdE==rs1D | rdE==rs2D).
  - Response: stallF=1, stallD=1, flushE=1 in the same cycle.
- Redirect: pcsrcE=1 gives flushD=1 and flushE=1.
  - If lwstall is also active, the redirect dominates: stallF=0 and stallD=0 (the wrong-path load-use is discarded).
- Multi-cycle FSM, states IDLE and BUSY:
  - IDLE, mcstartE=1, mcdoneE=0: go to BUSY, counter cleared. stallF/D/E=1 combinationally in this cycle.
  - IDLE, mcstartE=1, mcdoneE=1: zero-wait op. No stall, stay IDLE.
  - BUSY, mcdoneE=0: stallF/D/E=1, counter+1, mc_busy=1.
  - BUSY, mcdoneE=1: stalls deassert in this cycle so the op advances to memory. Next state IDLE.
  - BUSY, counter==MC_TIMEOUT-1 without done: mc_err<=1 (sticky until reset), next state IDLE. The stall releases in the following cycle.
- While BUSY:
  - pcsrcE and lwstall are ignored.
  - flushE=0, because execute holds the stalled op.
- Forwarding remains active in every state.
- Registered state: FSM state, counter, mc_err. All other outputs are combinational from inputs and state.

Optional Feature:
- Macro HAZARD_PERF_EN.
- When defined, the block adds 32-bit outputs perf_stall_cyc, perf_flush_cnt and perf_mc_cnt:
  - perf_stall_cyc increments each cycle stallF=1.
  - perf_flush_cnt increments on each pcsrcE flush.
  - perf_mc_cnt increments on each IDLE->BUSY transition.
  - All three saturate at all-ones and reset to 0.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RESULTSRC_LOAD=2'b01.
  - mc_state_t enum: IDLE, BUSY.
- Sub-module fwd_sel_unit (one source-register comparator set producing fwd_sel_t), instantiated twice, once for A and once for B.

Test Plan:
- rdM=5, regwriteM=1, rdW=5, regwriteW=1, rs1E=5 -> forwardAE=10. Drop regwriteM -> forwardAE=01. Set rdM=rdW=0 -> forwardAE=00.
- resultsrcE=01, rdE=7, rs2D=7 -> stallF=stallD=flushE=1 for exactly one cycle. Next cycle with resultsrcE=00 -> all 0.
- pcsrcE=1 together with a lwstall condition -> flushD=flushE=1, stallF=stallD=0.
- mcstartE=1, mcdoneE after 5 cycles -> stalls high for 5 cycles, mc_busy high for 5 cycles, stalls low on the done cycle, FSM returns to IDLE.
- mcstartE=1 with mcdoneE never asserted, MC_TIMEOUT=8 -> mc_err=1 after 8 BUSY cycles, return to IDLE, mc_err held until rst=0.
- rst=0 asserted during the 3rd BUSY cycle -> next cycle state=IDLE, all outputs 0, counter=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mc_state_t;

   localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline <-> hazard controller signal bundle.
// With HAZARD_PERF_EN defined, the bundle also carries the 32-bit performance counters.
interface hazard_controller_if;
   logic [4:0] rs1D, rs2D, rs1E, rs2E;
   logic [4:0] rdE, rdM, rdW;
   logic       regwriteM, regwriteW;
   logic [1:0] resultsrcE;
   logic       pcsrcE, mcstartE, mcdoneE;
   logic [1:0] forwardAE, forwardBE;
   logic       stallF, stallD, stallE;
   logic       flushD, flushE;
   logic       mc_busy, mc_err;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_mc_cnt;

   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
             resultsrcE, pcsrcE, mcstartE, mcdoneE,
      input  forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
             mc_busy, mc_err, perf_stall_cyc, perf_flush_cnt, perf_mc_cnt
   );
   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
             resultsrcE, pcsrcE, mcstartE, mcdoneE,
      output forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
             mc_busy, mc_err, perf_stall_cyc, perf_flush_cnt, perf_mc_cnt
   );
`else
   modport master (
      output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
             resultsrcE, pcsrcE, mcstartE, mcdoneE,
      input  forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
             mc_busy, mc_err
   );
   modport slave (
      input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW, regwriteM, regwriteW,
             resultsrcE, pcsrcE, mcstartE, mcdoneE,
      output forwardAE, forwardBE, stallF, stallD, stallE, flushD, flushE,
             mc_busy, mc_err
   );
`endif
endinterface

// File: rtl/hazard_controller_fwd_sel_unit.sv
// Operand forwarding select for one execute-stage source register.
module fwd_sel_unit
   import hazard_pkg::*;
(
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rdM,
   input  logic [4:0] i_rdW,
   input  logic       i_regwriteM,
   input  logic       i_regwriteW,
   output fwd_sel_t   o_sel
);

   logic w_hit_mem, w_hit_wb;

   assign w_hit_mem = i_regwriteM && (i_rdM != 5'd0) && (i_rdM == i_rs);
   assign w_hit_wb  = i_regwriteW && (i_rdW != 5'd0) && (i_rdW == i_rs);

   // Memory stage holds the younger value, so it wins over writeback.
   always_comb begin
      o_sel = FWD_RF;
      if (w_hit_mem)
         o_sel = FWD_MEM;
      else if (w_hit_wb)
         o_sel = FWD_WB;
   end

endmodule

// File: rtl/hazard_controller.sv
// Hazard/sequencing controller: forwarding, load-use and redirect stalls/flushes,
// multi-cycle execute sequencer with watchdog. Optional macro: HAZARD_PERF_EN.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 7
)(
   input  logic                clk,
   input  logic                rst,
   hazard_controller_if.slave  hz
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MC_TIMEOUT - 1);

   mc_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mc_err;

   fwd_sel_t w_selA, w_selB;
   logic     w_lwstall, w_busy, w_mc_enter, w_mc_hold, w_timeout;
   logic     w_redirect, w_lw_eff;

   fwd_sel_unit u_fwdA (
      .i_rs(hz.rs1E), .i_rdM(hz.rdM), .i_rdW(hz.rdW),
      .i_regwriteM(hz.regwriteM), .i_regwriteW(hz.regwriteW), .o_sel(w_selA)
   );

   fwd_sel_unit u_fwdB (
      .i_rs(hz.rs2E), .i_rdM(hz.rdM), .i_rdW(hz.rdW),
      .i_regwriteM(hz.regwriteM), .i_regwriteW(hz.regwriteW), .o_sel(w_selB)
   );

   assign w_lwstall  = (hz.resultsrcE == RESULTSRC_LOAD) && (hz.rdE != 5'd0) &&
                       ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
   assign w_busy     = (r_state == BUSY);
   assign w_mc_enter = !w_busy && hz.mcstartE && !hz.mcdoneE;
   assign w_mc_hold  = w_mc_enter || (w_busy && !hz.mcdoneE);
   assign w_timeout  = w_busy && !hz.mcdoneE && (r_cnt == CNT_LAST);

   // A multi-cycle op in execute owns the front of the pipe; redirect beats load-use.
   assign w_redirect = !w_busy && !w_mc_enter && hz.pcsrcE;
   assign w_lw_eff   = !w_busy && !w_mc_enter && w_lwstall && !hz.pcsrcE;

   assign hz.forwardAE = rst ? w_selA : FWD_RF;
   assign hz.forwardBE = rst ? w_selB : FWD_RF;
   assign hz.stallF    = rst && (w_mc_hold || w_lw_eff);
   assign hz.stallD    = rst && (w_mc_hold || w_lw_eff);
   assign hz.stallE    = rst && w_mc_hold;
   assign hz.flushD    = rst && w_redirect;
   assign hz.flushE    = rst && (w_redirect || w_lw_eff);
   assign hz.mc_busy   = rst && w_busy;
   assign hz.mc_err    = rst && r_mc_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_mc_err <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_mc_enter) begin
                  r_state <= BUSY;
                  r_cnt   <= '0;
               end
            end
            BUSY: begin
               if (hz.mcdoneE) begin
                  r_state <= IDLE;
               end else if (w_timeout) begin
                  r_mc_err <= 1'b1;
                  r_state  <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall, r_perf_flush, r_perf_mc;

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
         r_perf_mc    <= '0;
      end else begin
         r_perf_stall <= sat_inc(r_perf_stall, hz.stallF);
         r_perf_flush <= sat_inc(r_perf_flush, w_redirect);
         r_perf_mc    <= sat_inc(r_perf_mc, w_mc_enter);
      end
   end

   assign hz.perf_stall_cyc = r_perf_stall;
   assign hz.perf_flush_cnt = r_perf_flush;
   assign hz.perf_mc_cnt    = r_perf_mc;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller (MC_TIMEOUT=8).
module tb_hazard_controller;
   import hazard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   hazard_controller_if hz ();

   hazard_controller #(.MC_TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .hz(hz)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      hz.rs1D = 0; hz.rs2D = 0; hz.rs1E = 0; hz.rs2E = 0;
      hz.rdE = 0; hz.rdM = 0; hz.rdW = 0;
      hz.regwriteM = 0; hz.regwriteW = 0; hz.resultsrcE = 2'b00;
      hz.pcsrcE = 0; hz.mcstartE = 0; hz.mcdoneE = 0;
   endtask

   task automatic chk_ctl(input string tag, input logic [4:0] exp_sd_sd_fe);
      chk({tag, "_stallF"}, {31'd0, hz.stallF}, {31'd0, exp_sd_sd_fe[4]});
      chk({tag, "_stallD"}, {31'd0, hz.stallD}, {31'd0, exp_sd_sd_fe[3]});
      chk({tag, "_stallE"}, {31'd0, hz.stallE}, {31'd0, exp_sd_sd_fe[2]});
      chk({tag, "_flushD"}, {31'd0, hz.flushD}, {31'd0, exp_sd_sd_fe[1]});
      chk({tag, "_flushE"}, {31'd0, hz.flushE}, {31'd0, exp_sd_sd_fe[0]});
   endtask

   initial begin
      // Reset: outputs forced low even with a matching forward condition present.
      clear_inputs();
      hz.rdM = 5; hz.regwriteM = 1; hz.rs1E = 5; hz.mcstartE = 1;
      #1;
      chk("rst_fwdA", {30'd0, hz.forwardAE}, 32'd0);
      chk_ctl("rst", 5'b00000);
      tick(); tick();
      chk("rst_busy", {31'd0, hz.mc_busy}, 32'd0);
      chk("rst_err", {31'd0, hz.mc_err}, 32'd0);
      chk("rst_state", {31'd0, dut.r_state}, {31'd0, IDLE});
      clear_inputs();
      rst = 1'b1;
      tick();

      // Forwarding priority
      hz.rdM = 5; hz.regwriteM = 1; hz.rdW = 5; hz.regwriteW = 1; hz.rs1E = 5;
      #1;
      chk("fwd_mem", {30'd0, hz.forwardAE}, 32'd2);
      chk("fwd_B_none", {30'd0, hz.forwardBE}, 32'd0);
      hz.regwriteM = 0;
      #1;
      chk("fwd_wb", {30'd0, hz.forwardAE}, 32'd1);
      hz.rdM = 0; hz.rdW = 0; hz.regwriteM = 1; hz.rs1E = 0;
      #1;
      chk("fwd_x0", {30'd0, hz.forwardAE}, 32'd0);
      hz.rdM = 3; hz.rs2E = 3; hz.rdW = 4; hz.rs1E = 4;
      #1;
      chk("fwd_mix_A", {30'd0, hz.forwardAE}, 32'd1);
      chk("fwd_mix_B", {30'd0, hz.forwardBE}, 32'd2);
      clear_inputs();
      tick();

      // Load-use for exactly one cycle
      hz.resultsrcE = 2'b01; hz.rdE = 7; hz.rs2D = 7;
      #1;
      chk_ctl("lw", 5'b11001);
      tick();
      hz.resultsrcE = 2'b00;
      #1;
      chk_ctl("lw_after", 5'b00000);
      hz.resultsrcE = 2'b01; hz.rdE = 0; hz.rs1D = 0; hz.rs2D = 0;
      #1;
      chk_ctl("lw_x0", 5'b00000);
      clear_inputs();
      tick();

      // Redirect dominates a simultaneous load-use
      hz.resultsrcE = 2'b01; hz.rdE = 7; hz.rs2D = 7; hz.pcsrcE = 1;
      #1;
      chk_ctl("redir_lw", 5'b00011);
      clear_inputs();
      tick();

      // Multi-cycle op, done on the 5th BUSY cycle
      hz.mcstartE = 1;
      #1;
      chk_ctl("mc_enter", 5'b11100);
      chk("mc_enter_busy", {31'd0, hz.mc_busy}, 32'd0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         hz.pcsrcE = (i == 3);
         hz.resultsrcE = (i == 2) ? 2'b01 : 2'b00; hz.rdE = 9; hz.rs1D = 9;
         #1;
         chk($sformatf("mc_busy_c%0d", i), {31'd0, hz.mc_busy}, 32'd1);
         chk_ctl($sformatf("mc_hold_c%0d", i), 5'b11100);
      end
      tick();
      hz.pcsrcE = 0; hz.resultsrcE = 2'b00;
      hz.mcdoneE = 1;
      #1;
      chk("mc_done_busy", {31'd0, hz.mc_busy}, 32'd1);
      chk_ctl("mc_done", 5'b00000);
      tick();
      clear_inputs();
      #1;
      chk("mc_idle_busy", {31'd0, hz.mc_busy}, 32'd0);
      chk("mc_idle_err", {31'd0, hz.mc_err}, 32'd0);

      // Zero-wait op: no stall, stay IDLE
      hz.mcstartE = 1; hz.mcdoneE = 1;
      #1;
      chk_ctl("mc_zero", 5'b00000);
      tick();
      chk("mc_zero_busy", {31'd0, hz.mc_busy}, 32'd0);
      clear_inputs();
      tick();

      // Watchdog: 8 BUSY cycles without done
      hz.mcstartE = 1;
      tick();
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) hz.mcstartE = 0;
         #1;
         chk($sformatf("to_busy_c%0d", i), {31'd0, hz.mc_busy}, 32'd1);
         chk($sformatf("to_stall_c%0d", i), {31'd0, hz.stallF}, 32'd1);
         chk($sformatf("to_err_c%0d", i), {31'd0, hz.mc_err}, 32'd0);
         tick();
      end
      chk("to_idle_busy", {31'd0, hz.mc_busy}, 32'd0);
      chk("to_idle_stall", {31'd0, hz.stallF}, 32'd0);
      chk("to_err_set", {31'd0, hz.mc_err}, 32'd1);
      tick(); tick();
      chk("to_err_sticky", {31'd0, hz.mc_err}, 32'd1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("to_err_clr", {31'd0, hz.mc_err}, 32'd0);
      tick();

      // Reset in the 3rd BUSY cycle
      hz.mcstartE = 1;
      tick(); tick(); tick();
      #1;
      chk("rb_busy_pre", {31'd0, hz.mc_busy}, 32'd1);
      chk("rb_cnt_pre", {28'd0, dut.r_cnt}, 32'd2);
      rst = 1'b0;
      #1;
      chk_ctl("rb_gated", 5'b00000);
      chk("rb_busy_gated", {31'd0, hz.mc_busy}, 32'd0);
      tick();
      chk("rb_state", {31'd0, dut.r_state}, {31'd0, IDLE});
      chk("rb_cnt", {28'd0, dut.r_cnt}, 32'd0);
      hz.mcstartE = 0;
      rst = 1'b1;
      #1;
      chk("rb_busy_post", {31'd0, hz.mc_busy}, 32'd0);
      chk_ctl("rb_post", 5'b00000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
